// File: rtl/scrambler_pkg.sv
// ---------------------------------------------------------------------------
// scrambler_pkg
// Shared definitions for the 802.11a scrambler/descrambler (x^7 + x^4 + 1).
// Contents: LFSR width and taps, default seed, mode and FSM state encodings,
// and the feedback helper used by the unrolled step logic.
// ---------------------------------------------------------------------------
package scrambler_pkg;

    localparam int LFSR_W    = 7;
    localparam int TAP_HI    = 6;
    localparam int TAP_LO    = 3;
    localparam int SYNC_BITS = 7;

    localparam logic [LFSR_W-1:0] SCR_DEF_SEED = 7'h7F;

    typedef enum logic {
        SCR   = 1'b0,
        DESCR = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_e;

    // Feedback bit of the generator: x^7 + x^4 maps onto state bits 6 and 3.
    function automatic logic fbit(input logic [LFSR_W-1:0] s);
        return s[TAP_HI] ^ s[TAP_LO];
    endfunction

endpackage

// File: rtl/scrambler_par_if.sv
// ---------------------------------------------------------------------------
// scrambler_par_if
// Valid/ready streaming bus around the scrambler.
//   in_valid/in_ready/in_data/in_sof/in_eof : upstream beat handshake
//   out_valid/out_ready/out_data/out_eof    : downstream beat handshake
// Modports: master = the side feeding beats in and taking results out,
//           slave  = the scrambler itself.
// ---------------------------------------------------------------------------
interface scrambler_par_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_sof;
    logic         in_eof;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_eof;

    modport master (
        output in_valid, in_data, in_sof, in_eof, out_ready,
        input  in_ready, out_valid, out_data, out_eof
    );

    modport slave (
        input  in_valid, in_data, in_sof, in_eof, out_ready,
        output in_ready, out_valid, out_data, out_eof
    );
endinterface

// File: rtl/lfsr_step_w.sv
// ---------------------------------------------------------------------------
// lfsr_step_w
// Combinational unroll of W scrambler bit steps, bit 0 first in time.
//   i_state      : LFSR state before the beat
//   i_x          : input bits of the beat
//   i_sync       : 1 while the descrambler is still collecting seed bits
//   i_count      : number of seed bits already collected
//   o_y          : output bits
//   o_state      : LFSR state after the beat
//   o_count      : seed bit count after the beat
//   o_sync_done  : seed collection completed inside this beat
//   o_sync_state : LFSR state at the exact bit where collection completed
// ---------------------------------------------------------------------------
module lfsr_step_w
    import scrambler_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [LFSR_W-1:0] i_state,
    input  logic [W-1:0]      i_x,
    input  logic              i_sync,
    input  logic [2:0]        i_count,
    output logic [W-1:0]      o_y,
    output logic [LFSR_W-1:0] o_state,
    output logic [2:0]        o_count,
    output logic              o_sync_done,
    output logic [LFSR_W-1:0] o_sync_state
);

    // Walk the beat bit by bit. While collecting, the received bit is shifted
    // straight into the state (it equals the transmitter's feedback bit because
    // the SERVICE bits are zero). Once seven bits are in, the remaining bits of
    // the same beat switch to normal additive descrambling.
    always_comb begin
        logic [LFSR_W-1:0] w_s;
        logic [2:0]        w_c;
        logic              w_sync;
        logic              w_f;

        w_s          = i_state;
        w_c          = i_count;
        w_sync       = i_sync;
        w_f          = 1'b0;
        o_y          = '0;
        o_sync_done  = 1'b0;
        o_sync_state = i_state;

        for (int i = 0; i < W; i++) begin
            w_f = fbit(w_s);
            if (w_sync) begin
                o_y[i] = 1'b0;
                w_s    = {w_s[LFSR_W-2:0], i_x[i]};
                w_c    = w_c + 3'd1;
                if (w_c == 3'(SYNC_BITS)) begin
                    w_sync       = 1'b0;
                    o_sync_done  = 1'b1;
                    o_sync_state = w_s;
                end
            end else begin
                o_y[i] = i_x[i] ^ w_f;
                w_s    = {w_s[LFSR_W-2:0], w_f};
            end
        end

        o_state = w_s;
        o_count = w_c;
    end

endmodule

// File: rtl/scrambler_par.sv
// ---------------------------------------------------------------------------
// scrambler_par
// W-bit-per-beat 802.11a scrambler (mode 0) / descrambler with seed
// recovery (mode 1), one beat per cycle, one registered output stage.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_mode         : 0 scramble, 1 descramble; taken on the SOF beat
//   i_seed_in      : scramble seed (0 selects DEF_SEED); taken on SOF beat
//   bus            : in/out valid-ready stream (scrambler_par_if.slave)
//   o_seed_out     : recovered LFSR state, held until next recovery
//   o_seed_valid   : one-cycle pulse with the beat that recovered the seed
//   o_err          : one-cycle pulse with the beat that broke the protocol
// ---------------------------------------------------------------------------
module scrambler_par
    import scrambler_pkg::*;
#(
    parameter int                W        = 8,
    parameter logic [LFSR_W-1:0] DEF_SEED = SCR_DEF_SEED
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mode,
    input  logic [LFSR_W-1:0] i_seed_in,
    scrambler_par_if.slave    bus,
    output logic [LFSR_W-1:0] o_seed_out,
    output logic              o_seed_valid,
    output logic              o_err
);

    state_e            r_state;
    logic [LFSR_W-1:0] r_lfsr;
    logic [2:0]        r_count;
    logic              r_out_valid;
    logic [W-1:0]      r_out_data;
    logic              r_out_eof;
    logic [LFSR_W-1:0] r_seed_out;
    logic              r_seed_valid;
    logic              r_err;

    logic              w_accept;
    logic              w_drop;
    logic [LFSR_W-1:0] w_start_seed;
    logic [LFSR_W-1:0] w_step_state;
    logic              w_step_sync;
    logic [2:0]        w_step_count;
    logic [W-1:0]      w_y;
    logic [LFSR_W-1:0] w_next_state;
    logic [2:0]        w_next_count;
    logic              w_sync_done;
    logic [LFSR_W-1:0] w_sync_state;
    logic              w_still_sync;

    assign bus.in_ready = !r_out_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;

    // A beat without SOF while idle belongs to no frame and is thrown away.
    assign w_drop       = !bus.in_sof && (r_state == IDLE);

    // An SOF beat always starts from a fresh seed, even mid-frame, so the
    // step logic is fed the new seed/mode instead of the running state.
    assign w_start_seed = (i_seed_in == '0) ? DEF_SEED : i_seed_in;
    assign w_step_state = bus.in_sof ? w_start_seed : r_lfsr;
    assign w_step_sync  = bus.in_sof ? (mode_e'(i_mode) == DESCR) : (r_state == SYNC);
    assign w_step_count = bus.in_sof ? 3'd0 : r_count;
    assign w_still_sync = w_step_sync && !w_sync_done;

    lfsr_step_w #(
        .W (W)
    ) u_step (
        .i_state      (w_step_state),
        .i_x          (bus.in_data),
        .i_sync       (w_step_sync),
        .i_count      (w_step_count),
        .o_y          (w_y),
        .o_state      (w_next_state),
        .o_count      (w_next_count),
        .o_sync_done  (w_sync_done),
        .o_sync_state (w_sync_state)
    );

    // Frame FSM plus output register. Everything advances only on an accepted
    // beat; otherwise the output beat is held until the sink takes it. The
    // status pulses are registered so they line up with the output beat of
    // the input beat that caused them. A frame that ends while still
    // collecting seed bits is a protocol error and never reports a seed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_lfsr       <= SCR_DEF_SEED;
            r_count      <= 3'd0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_eof    <= 1'b0;
            r_seed_out   <= '0;
            r_seed_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_seed_valid <= 1'b0;
            r_err        <= 1'b0;
            if (w_accept) begin
                if (w_drop) begin
                    r_out_valid <= 1'b0;
                    r_err       <= 1'b1;
                end else begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_y;
                    r_out_eof   <= bus.in_eof;
                    r_lfsr      <= w_next_state;
                    r_count     <= w_next_count;
                    if (bus.in_sof && (r_state != IDLE)) begin
                        r_err <= 1'b1;
                    end
                    if (w_sync_done) begin
                        r_seed_out   <= w_sync_state;
                        r_seed_valid <= 1'b1;
                    end
                    if (bus.in_eof) begin
                        r_state <= IDLE;
                        if (w_still_sync) begin
                            r_err <= 1'b1;
                        end
                    end else if (w_still_sync) begin
                        r_state <= SYNC;
                    end else begin
                        r_state <= RUN;
                    end
                end
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_eof   = r_out_eof;
    assign o_seed_out    = r_seed_out;
    assign o_seed_valid  = r_seed_valid;
    assign o_err         = r_err;

endmodule

// File: tb/tb_scrambler_par.sv
// ---------------------------------------------------------------------------
// tb_scrambler_par
// Directed bench for scrambler_par with a W=8 and a W=5 instance. Expected
// values come from the published 127-bit 802.11a sequence (all-ones seed),
// packed with the first bit in time at bit 0.
// ---------------------------------------------------------------------------
module tb_scrambler_par;

    logic       clk;
    logic       rst_n;
    logic       mode8;
    logic [6:0] seed8;
    logic [6:0] seedOut8;
    logic       seedValid8;
    logic       err8;
    logic       mode5;
    logic [6:0] seed5;
    logic [6:0] seedOut5;
    logic       seedValid5;
    logic       err5;

    int compareCount = 0;
    int failCount    = 0;

    scrambler_par_if #(.W(8)) bus8 ();
    scrambler_par_if #(.W(5)) bus5 ();

    scrambler_par #(.W(8), .DEF_SEED(7'h7F)) u8 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_mode       (mode8),
        .i_seed_in    (seed8),
        .bus          (bus8),
        .o_seed_out   (seedOut8),
        .o_seed_valid (seedValid8),
        .o_err        (err8)
    );

    scrambler_par #(.W(5), .DEF_SEED(7'h7F)) u5 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_mode       (mode5),
        .i_seed_in    (seed5),
        .bus          (bus5),
        .o_seed_out   (seedOut5),
        .o_seed_valid (seedValid5),
        .o_err        (err5)
    );

    // Scrambled zero bytes from seed 7'h7F; byte 15 wraps the 127-bit period.
    logic [7:0] exp8 [17] = '{8'h70, 8'h4F, 8'h93, 8'h40, 8'h64, 8'h74, 8'h6D, 8'h30,
                              8'h2B, 8'hE7, 8'h2D, 8'h54, 8'h5F, 8'h8A, 8'h1D, 8'h7F,
                              8'hB8};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus8(input logic v, input logic [7:0] d, input logic sof, input logic eof);
        bus8.in_valid = v;
        bus8.in_data  = d;
        bus8.in_sof   = sof;
        bus8.in_eof   = eof;
    endtask

    task automatic applyStimulus5(input logic v, input logic [4:0] d, input logic sof, input logic eof);
        bus5.in_valid = v;
        bus5.in_data  = d;
        bus5.in_sof   = sof;
        bus5.in_eof   = eof;
    endtask

    task automatic checkOutput8(input string tag, input logic expValid, input logic [7:0] expData,
                                input logic expEof, input logic expSv, input logic expErr);
        @(negedge clk);
        check({tag, ".valid"}, 16'(bus8.out_valid), 16'(expValid));
        if (expValid) begin
            check({tag, ".data"}, 16'(bus8.out_data), 16'(expData));
            check({tag, ".eof"}, 16'(bus8.out_eof), 16'(expEof));
        end
        check({tag, ".seed_valid"}, 16'(seedValid8), 16'(expSv));
        check({tag, ".err"}, 16'(err8), 16'(expErr));
    endtask

    task automatic checkOutput5(input string tag, input logic expValid, input logic [4:0] expData,
                                input logic expEof, input logic expSv, input logic expErr);
        @(negedge clk);
        check({tag, ".valid"}, 16'(bus5.out_valid), 16'(expValid));
        if (expValid) begin
            check({tag, ".data"}, 16'(bus5.out_data), 16'(expData));
            check({tag, ".eof"}, 16'(bus5.out_eof), 16'(expEof));
        end
        check({tag, ".seed_valid"}, 16'(seedValid5), 16'(expSv));
        check({tag, ".err"}, 16'(err5), 16'(expErr));
    endtask

    initial begin
        logic [4:0] in5  [4];
        logic [4:0] exp5 [4];
        logic [7:0] readyPat;
        logic       modelPending;
        logic       expInReady;
        logic       acc;
        int         idx;
        int         k;

        // Descrambler input for W=5: scrambled-zero stream from seed 7'h7F,
        // with payload 5'h15 added into the third beat.
        in5  = '{5'h10, 5'h1B, 5'h06, 5'h06};
        exp5 = '{5'h00, 5'h00, 5'h15, 5'h00};
        readyPat = 8'b0110_1001;

        rst_n = 1'b0;
        mode8 = 1'b0;
        seed8 = 7'h7F;
        mode5 = 1'b0;
        seed5 = 7'h7F;
        bus8.out_ready = 1'b1;
        bus5.out_ready = 1'b1;
        applyStimulus8(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus5(1'b0, 5'h00, 1'b0, 1'b0);

        // Reset values
        @(negedge clk);
        check("rst.out_valid", 16'(bus8.out_valid), 16'd0);
        check("rst.out_data", 16'(bus8.out_data), 16'd0);
        check("rst.out_eof", 16'(bus8.out_eof), 16'd0);
        check("rst.seed_out", 16'(seedOut8), 16'd0);
        check("rst.seed_valid", 16'(seedValid8), 16'd0);
        check("rst.err", 16'(err8), 16'd0);
        check("rst.in_ready", 16'(bus8.in_ready), 16'd1);
        check("rst.out_valid5", 16'(bus5.out_valid), 16'd0);
        rst_n = 1'b1;

        // Scramble 17 zero bytes from seed 7'h7F; beat 17 keeps running
        for (int i = 0; i < 17; i++) begin
            applyStimulus8(1'b1, 8'h00, i == 0, i == 16);
            checkOutput8($sformatf("scr7f[%0d]", i), 1'b1, exp8[i], i == 16, 1'b0, 1'b0);
        end
        applyStimulus8(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput8("scr7f_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Zero seed falls back to the default seed
        seed8 = 7'h00;
        applyStimulus8(1'b1, 8'h00, 1'b1, 1'b0);
        checkOutput8("seed0[0]", 1'b1, 8'h70, 1'b0, 1'b0, 1'b0);
        applyStimulus8(1'b1, 8'h00, 1'b0, 1'b1);
        checkOutput8("seed0[1]", 1'b1, 8'h4F, 1'b1, 1'b0, 1'b0);
        applyStimulus8(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput8("seed0_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Descramble the same stream: all zero, seed 7'h07 recovered in beat 0
        mode8 = 1'b1;
        seed8 = 7'h7F;
        for (int i = 0; i < 17; i++) begin
            applyStimulus8(1'b1, exp8[i], i == 0, i == 16);
            checkOutput8($sformatf("descr[%0d]", i), 1'b1, 8'h00, i == 16, i == 0, 1'b0);
            if (i == 0) check("descr.seed_out", 16'(seedOut8), 16'h0007);
        end
        applyStimulus8(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput8("descr_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Backpressure: 6 zero bytes scrambled while out_ready follows a pattern
        mode8 = 1'b0;
        idx = 0;
        k = 0;
        modelPending = 1'b0;
        applyStimulus8(1'b1, 8'h00, 1'b1, 1'b0);
        for (int cyc = 0; cyc < 40 && k < 6; cyc++) begin
            bus8.out_ready = readyPat[cyc % 8];
            #1;
            expInReady = !modelPending || bus8.out_ready;
            check("stall.in_ready", 16'(bus8.in_ready), 16'(expInReady));
            check("stall.out_valid", 16'(bus8.out_valid), 16'(modelPending));
            if (modelPending) begin
                check($sformatf("stall.data[%0d]", k), 16'(bus8.out_data), 16'(exp8[k]));
                if (bus8.out_ready) k++;
            end
            acc = bus8.in_valid && expInReady;
            modelPending = acc || (modelPending && !bus8.out_ready);
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 6) applyStimulus8(1'b1, 8'h00, 1'b0, idx == 5);
                else         applyStimulus8(1'b0, 8'h00, 1'b0, 1'b0);
            end
        end
        check("stall.beats_out", 16'(k), 16'd6);
        bus8.out_ready = 1'b1;
        checkOutput8("stall_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Non-SOF beat in IDLE is dropped with an error
        applyStimulus8(1'b1, 8'hAA, 1'b0, 1'b0);
        checkOutput8("drop", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus8(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput8("drop_after", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // SOF mid-frame restarts from the new seed and flags an error
        applyStimulus8(1'b1, 8'h00, 1'b1, 1'b0);
        checkOutput8("resof[0]", 1'b1, 8'h70, 1'b0, 1'b0, 1'b0);
        applyStimulus8(1'b1, 8'h00, 1'b1, 1'b0);
        checkOutput8("resof[1]", 1'b1, 8'h70, 1'b0, 1'b0, 1'b1);
        applyStimulus8(1'b1, 8'h00, 1'b0, 1'b1);
        checkOutput8("resof[2]", 1'b1, 8'h4F, 1'b1, 1'b0, 1'b0);
        applyStimulus8(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput8("resof_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // W=5 descramble: seed collection completes inside the second beat
        mode5 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus5(1'b1, in5[i], i == 0, i == 3);
            checkOutput5($sformatf("w5[%0d]", i), 1'b1, exp5[i], i == 3, i == 1, 1'b0);
            if (i == 1) check("w5.seed_out", 16'(seedOut5), 16'h0007);
        end

        // W=5 SOF+EOF descramble beat is too short to recover a seed
        applyStimulus5(1'b1, 5'h1F, 1'b1, 1'b1);
        checkOutput5("w5short", 1'b1, 5'h00, 1'b1, 1'b0, 1'b1);
        applyStimulus5(1'b1, 5'h0A, 1'b0, 1'b0);
        checkOutput5("w5short_idle", 1'b0, 5'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus5(1'b0, 5'h00, 1'b0, 1'b0);
        checkOutput5("w5_quiet", 1'b0, 5'h00, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-frame discards the pending beat
        mode8 = 1'b0;
        bus8.out_ready = 1'b0;
        applyStimulus8(1'b1, 8'h00, 1'b1, 1'b0);
        checkOutput8("arst_pre", 1'b1, 8'h70, 1'b0, 1'b0, 1'b0);
        applyStimulus8(1'b1, 8'h00, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst.out_valid", 16'(bus8.out_valid), 16'd0);
        check("arst.out_data", 16'(bus8.out_data), 16'd0);
        check("arst.seed_out", 16'(seedOut8), 16'd0);
        check("arst.in_ready", 16'(bus8.in_ready), 16'd1);
        applyStimulus8(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bus8.out_ready = 1'b1;
        applyStimulus8(1'b1, 8'h00, 1'b0, 1'b0);
        checkOutput8("arst_idle_drop", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus8(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput8("arst_quiet", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
